// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : queue_pkg
//  Description : Shared types and helpers for the queue forwarder: FSM state
//                encoding, index-width derivation and saturating increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package queue_pkg;

    // Forwarder transaction phases.
    typedef enum logic [1:0] {
        FWD_IDLE = 2'd0,
        FWD_SEND = 2'd1,
        FWD_ACK  = 2'd2
    } fwd_state_t;

    // Widest counter the saturating helper can handle.
    localparam int c_SAT_MAX_W = 64;

    // Width of a queue index; a single queue still needs one bit of port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment value, holding at the all-ones pattern of the given width.
    function automatic logic [c_SAT_MAX_W-1:0] sat_inc(
        input logic [c_SAT_MAX_W-1:0] value,
        input int                     width
    );
        logic [c_SAT_MAX_W-1:0] max_v;
        max_v = {c_SAT_MAX_W{1'b1}} >> (c_SAT_MAX_W - width);
        return (value >= max_v) ? max_v : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/queue_forwarder_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at all-ones instead of wrapping.
//                COUNTER_SIZE may be at most 64 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import queue_pkg::*;
#(
    parameter int COUNTER_SIZE = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clear,
    output logic [COUNTER_SIZE-1:0] count
);

    logic [COUNTER_SIZE-1:0] r_count;

    // Count events; clear wins over a simultaneous increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= COUNTER_SIZE'(sat_inc(64'(r_count), COUNTER_SIZE));
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/queue_forwarder.sv
`default_nettype none
// ============================================================================
//  Module      : queue_forwarder
//  Description : Takes a scheduler grant, pops the head packet of the granted
//                queue, forwards it over valid/ready and pulses consumed when
//                the transaction is done. Grants on empty queues are dropped
//                but still acknowledged. Keeps saturating served/dropped
//                counters per queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_forwarder
    import queue_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PACKET_SIZE      = 64,
    parameter int COUNTER_SIZE     = 32,
    parameter int ID_W             = id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [ID_W-1:0]                        id,
    input  logic [NUMBER_OF_QUEUES-1:0]            empty,
    input  logic [NUMBER_OF_QUEUES*PACKET_SIZE-1:0] packetsIn,
    output logic [NUMBER_OF_QUEUES-1:0]            pop,
    output logic                                   consumed,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [PACKET_SIZE-1:0]                 m_packet,
    output logic [ID_W-1:0]                        m_id,
    output logic                                   busy,
    output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] servedCount,
    output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] droppedCount
);

    localparam logic [1:0] c_ST_IDLE = FWD_IDLE;
    localparam logic [1:0] c_ST_SEND = FWD_SEND;
    localparam logic [1:0] c_ST_ACK  = FWD_ACK;

    logic [1:0]                  r_state;
    logic [NUMBER_OF_QUEUES-1:0] r_pop;
    logic                        r_consumed;
    logic                        r_valid;
    logic [PACKET_SIZE-1:0]      r_packet;
    logic [ID_W-1:0]             r_id;
    logic                        r_busy;

    logic                        w_id_in_range;
    logic [ID_W-1:0]             w_sel;
    logic [NUMBER_OF_QUEUES-1:0] w_sel_onehot;
    logic [PACKET_SIZE-1:0]      w_head;
    logic                        w_sel_empty;
    logic                        w_grant;
    logic                        w_take;
    logic                        w_drop;
    logic                        w_accept;
    logic [NUMBER_OF_QUEUES-1:0] w_served_inc;
    logic [NUMBER_OF_QUEUES-1:0] w_drop_inc;

    // Out-of-range ids are folded onto queue 0 and always treated as a drop.
    assign w_id_in_range = (32'(id) < 32'(NUMBER_OF_QUEUES));
    assign w_sel         = w_id_in_range ? id : '0;

    // Decode the selected queue: one-hot strobe, head data and empty flag.
    always_comb begin
        w_sel_onehot = '0;
        w_head       = '0;
        w_sel_empty  = 1'b0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_head          = packetsIn[i*PACKET_SIZE +: PACKET_SIZE];
                w_sel_empty     = empty[i];
            end
        end
    end

    assign w_grant  = (r_state == c_ST_IDLE) & enable;
    assign w_take   = w_grant & w_id_in_range & ~w_sel_empty;
    assign w_drop   = w_grant & ~w_take;
    assign w_accept = (r_state == c_ST_SEND) & r_valid & m_ready;

    // Transaction sequencer: IDLE -> SEND -> ACK for real packets,
    // IDLE -> ACK for drops so the scheduler is always re-armed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_pop      <= '0;
            r_consumed <= 1'b0;
            r_valid    <= 1'b0;
            r_packet   <= '0;
            r_id       <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_pop      <= '0;
            r_consumed <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_take) begin
                        r_state  <= c_ST_SEND;
                        r_id     <= w_sel;
                        r_packet <= w_head;
                        r_pop    <= w_sel_onehot;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (w_drop) begin
                        r_state    <= c_ST_ACK;
                        r_consumed <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_SEND: begin
                    if (w_accept) begin
                        r_state    <= c_ST_ACK;
                        r_valid    <= 1'b0;
                        r_consumed <= 1'b1;
                    end
                end
                c_ST_ACK: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pop      = r_pop;
    assign consumed = r_consumed;
    assign m_valid  = r_valid;
    assign m_packet = r_packet;
    assign m_id     = r_id;
    assign busy     = r_busy;

    // Per-queue statistics: completions credited to the latched source id,
    // drops credited to the (folded) granted id.
    generate
        for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_counters
            assign w_served_inc[q] = w_accept & (r_id == ID_W'(q));
            assign w_drop_inc[q]   = w_drop & w_sel_onehot[q];

            sat_counter #(
                .COUNTER_SIZE (COUNTER_SIZE)
            ) u_served (
                .clock (clock),
                .reset (reset),
                .inc   (w_served_inc[q]),
                .clear (1'b0),
                .count (servedCount[q*COUNTER_SIZE +: COUNTER_SIZE])
            );

            sat_counter #(
                .COUNTER_SIZE (COUNTER_SIZE)
            ) u_dropped (
                .clock (clock),
                .reset (reset),
                .inc   (w_drop_inc[q]),
                .clear (1'b0),
                .count (droppedCount[q*COUNTER_SIZE +: COUNTER_SIZE])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_queue_forwarder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_forwarder
//  Description : Scoreboard bench for queue_forwarder. The driver acts as the
//                scheduler and queue front-ends; expected transactions are
//                queued and a negedge monitor retires them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_forwarder;

    localparam int NQ   = 4;
    localparam int PW   = 64;
    localparam int CW   = 4;
    localparam int IW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [IW-1:0]     id = '0;
    logic [NQ-1:0]     empty = '1;
    logic [NQ*PW-1:0]  packetsIn = '0;
    logic [NQ-1:0]     pop;
    logic              consumed;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [PW-1:0]     m_packet;
    logic [IW-1:0]     m_id;
    logic              busy;
    logic [NQ*CW-1:0]  servedCount;
    logic [NQ*CW-1:0]  droppedCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          q;
        logic [PW-1:0] pkt;
        bit          drop;
        bit          popped;
        bit          accepted;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   served_m[NQ];
    int   dropped_m[NQ];

    queue_forwarder #(
        .NUMBER_OF_QUEUES (NQ),
        .PACKET_SIZE      (PW),
        .COUNTER_SIZE     (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .id           (id),
        .empty        (empty),
        .packetsIn    (packetsIn),
        .pop          (pop),
        .consumed     (consumed),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_packet     (m_packet),
        .m_id         (m_id),
        .busy         (busy),
        .servedCount  (servedCount),
        .droppedCount (droppedCount)
    );

    always #5 clock = ~clock;

    function automatic void chk(input bit ok, input string name,
                                input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int sat_add(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic logic [PW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Compare every DUT counter with the reference tallies.
    function automatic void check_counts();
        for (int i = 0; i < NQ; i++) begin
            chk(servedCount[i*CW +: CW] == CW'(served_m[i]), "served_count",
                64'(servedCount[i*CW +: CW]), 64'(served_m[i]));
            chk(droppedCount[i*CW +: CW] == CW'(dropped_m[i]), "dropped_count",
                64'(droppedCount[i*CW +: CW]), 64'(dropped_m[i]));
        end
    endfunction

    // Monitor: retires scoreboard entries as the DUT presents pops, packets
    // and completion pulses.
    always @(negedge clock) begin
        if (reset) begin
            chk(!(consumed && m_valid), "consumed_valid_overlap",
                64'({consumed, m_valid}), 64'(0));
            if (pop != '0) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "pop_unexpected", 64'(pop), 64'(0));
                end else begin
                    mon_e = sb[0];
                    chk(!mon_e.drop && !mon_e.popped && (pop == NQ'(1 << mon_e.q)),
                        "pop_onehot", 64'(pop), 64'(NQ'(1 << mon_e.q)));
                    mon_e.popped = 1'b1;
                    sb[0] = mon_e;
                end
            end
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "valid_unexpected", 64'(m_valid), 64'(0));
                end else begin
                    mon_e = sb[0];
                    chk(!mon_e.drop, "valid_on_drop", 64'(m_valid), 64'(0));
                    chk(m_packet == mon_e.pkt, "m_packet", m_packet, mon_e.pkt);
                    chk(m_id == IW'(mon_e.q), "m_id", 64'(m_id), 64'(mon_e.q));
                    if (m_ready) mon_e.accepted = 1'b1;
                    sb[0] = mon_e;
                end
            end
            if (consumed) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "consumed_unexpected", 64'(consumed), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.drop) begin
                        chk(!mon_e.popped && !mon_e.accepted, "drop_completion",
                            64'({mon_e.popped, mon_e.accepted}), 64'(0));
                        dropped_m[mon_e.q] = sat_add(dropped_m[mon_e.q]);
                    end else begin
                        chk(mon_e.popped && mon_e.accepted, "send_completion",
                            64'({mon_e.popped, mon_e.accepted}), 64'(3));
                        served_m[mon_e.q] = sat_add(served_m[mon_e.q]);
                    end
                    check_counts();
                end
            end
        end
    end

    // One scheduler grant, with stall cycles of m_ready=0 while sending.
    task automatic run_txn(input int q, input bit is_empty, input int stall,
                           input logic [PW-1:0] pkt);
        exp_t e;
        for (int i = 0; i < NQ; i++) packetsIn[i*PW +: PW] = rand64();
        packetsIn[q*PW +: PW] = pkt;
        empty     = NQ'($urandom);
        empty[q]  = is_empty;
        id        = IW'(q);
        enable    = 1'b1;
        m_ready   = (stall == 0);
        e = '{q: q, pkt: pkt, drop: is_empty, popped: 1'b0, accepted: 1'b0};
        sb.push_back(e);
        @(posedge clock); #1;
        enable = 1'b0;
        id     = IW'($urandom);
        for (int i = 0; i < NQ; i++) packetsIn[i*PW +: PW] = rand64();
        empty  = NQ'($urandom);
        if (!is_empty) begin
            for (int s = 0; s < stall; s++) begin
                chk(m_valid && busy, "send_hold", 64'({m_valid, busy}), 64'(3));
                @(posedge clock); #1;
            end
            chk(m_valid && busy, "send_valid", 64'({m_valid, busy}), 64'(3));
            m_ready = 1'b1;
            @(posedge clock); #1;
            m_ready = 1'($urandom_range(0, 1));
        end
        chk(consumed && !m_valid && busy, "ack_consumed",
            64'({consumed, m_valid, busy}), 64'(5));
        @(posedge clock); #1;
        chk(!consumed && !busy, "back_idle", 64'({consumed, busy}), 64'(0));
    endtask

    initial begin
        logic [PW-1:0] pkt;
        exp_t e;
        for (int i = 0; i < NQ; i++) begin
            served_m[i]  = 0;
            dropped_m[i] = 0;
        end
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk(pop == '0, "reset_pop", 64'(pop), 64'(0));
        chk(!consumed, "reset_consumed", 64'(consumed), 64'(0));
        chk(!m_valid, "reset_m_valid", 64'(m_valid), 64'(0));
        chk(!busy, "reset_busy", 64'(busy), 64'(0));
        chk(m_packet == '0, "reset_m_packet", m_packet, 64'(0));
        chk(m_id == '0, "reset_m_id", 64'(m_id), 64'(0));
        check_counts();
        reset = 1'b1;
        @(posedge clock); #1;

        // Basic forward, backpressure and empty-grant cases.
        run_txn(2, 1'b0, 0, 64'hDEAD_BEEF);
        chk(servedCount[2*CW +: CW] == CW'(1), "basic_served2",
            64'(servedCount[2*CW +: CW]), 64'(1));
        run_txn(1, 1'b0, 5, rand64());
        run_txn(3, 1'b1, 0, rand64());
        chk(droppedCount[3*CW +: CW] == CW'(1), "empty_dropped3",
            64'(droppedCount[3*CW +: CW]), 64'(1));

        // Back-to-back: level enable on queue 0, one packet every 3 cycles.
        pkt = rand64();
        packetsIn[0 +: PW] = pkt;
        empty   = '0;
        id      = '0;
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = '{q: 0, pkt: pkt, drop: 1'b0, popped: 1'b0, accepted: 1'b0};
            sb.push_back(e);
        end
        repeat (10) @(posedge clock);
        #1 enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk(servedCount[0 +: CW] == CW'(4), "b2b_served0",
            64'(servedCount[0 +: CW]), 64'(4));
        chk(sb.size() == 0, "b2b_drained", 64'(sb.size()), 64'(0));
        chk(!busy, "b2b_idle", 64'(busy), 64'(0));

        // Reset while a packet is on the downstream port.
        pkt = rand64();
        packetsIn[1*PW +: PW] = pkt;
        empty   = '0;
        id      = IW'(1);
        m_ready = 1'b0;
        enable  = 1'b1;
        e = '{q: 1, pkt: pkt, drop: 1'b0, popped: 1'b0, accepted: 1'b0};
        sb.push_back(e);
        @(posedge clock); #1;
        enable = 1'b0;
        chk(m_valid, "pre_reset_valid", 64'(m_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk(!m_valid && !busy && pop == '0, "midsend_reset_outputs",
            64'({m_valid, busy, pop}), 64'(0));
        sb.delete();
        for (int i = 0; i < NQ; i++) begin
            served_m[i]  = 0;
            dropped_m[i] = 0;
        end
        check_counts();
        @(posedge clock); #1;
        reset = 1'b1;
        run_txn(2, 1'b0, 1, rand64());

        // Randomized mix of queues, empties and stalls.
        repeat (60) begin
            run_txn($urandom_range(0, NQ - 1), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), rand64());
        end

        // Saturation of the served counter on queue 0.
        repeat (20) run_txn(0, 1'b0, $urandom_range(0, 1), rand64());
        chk(servedCount[0 +: CW] == CW'(CMAX), "sat_served0",
            64'(servedCount[0 +: CW]), 64'(CMAX));

        chk(sb.size() == 0, "final_drained", 64'(sb.size()), 64'(0));
        check_counts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
